// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Captures decoded control, operands and register
// specifiers from ID, applying flush / stall / bubble with that priority.
// Killed slots carry all-zero control, so they cannot write registers,
// touch memory or branch. o_bubble_cnt counts inserted NOPs and saturates.
module id_ex_reg #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CNT  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_RegDst,
    input  logic               i_ALUSrc,
    input  logic               i_Branch,
    input  logic               i_MemRead,
    input  logic               i_MemWrite,
    input  logic               i_RegWrite,
    input  logic               i_MemtoReg,
    input  logic [1:0]         i_ALUOp,
    input  logic [NB_DATA-1:0] i_pc_next,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic [NB_DATA-1:0] i_imm,
    input  logic [NB_REG-1:0]  i_rs,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic               i_valid,
    input  logic               i_bubble,
    input  logic               i_stall,
    input  logic               i_flush,
    output logic               o_RegDst,
    output logic               o_ALUSrc,
    output logic               o_Branch,
    output logic               o_MemRead,
    output logic               o_MemWrite,
    output logic               o_RegWrite,
    output logic               o_MemtoReg,
    output logic [1:0]         o_ALUOp,
    output logic [NB_DATA-1:0] o_pc_next,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    output logic [NB_DATA-1:0] o_imm,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_rd,
    output logic               o_valid,
    output logic [NB_CNT-1:0]  o_bubble_cnt
);

    localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(1);
    localparam logic [NB_CNT-1:0] CNT_MAX = '1;

    // Control fields, packed so kill/hold treat them as one unit
    // order: RegDst, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg, ALUOp
    logic [8:0]         ctrl_d, ctrl_q;
    logic [NB_DATA-1:0] pc_next_d, pc_next_q;
    logic [NB_DATA-1:0] rs_data_d, rs_data_q;
    logic [NB_DATA-1:0] rt_data_d, rt_data_q;
    logic [NB_DATA-1:0] imm_d, imm_q;
    logic [NB_REG-1:0]  rs_d, rs_q;
    logic [NB_REG-1:0]  rt_d, rt_q;
    logic [NB_REG-1:0]  rd_d, rd_q;
    logic               valid_d, valid_q;
    logic [NB_CNT-1:0]  bubble_cnt_d, bubble_cnt_q;
    logic [NB_CNT-1:0]  cnt_inc;
    logic [8:0]         ctrl_in;

    assign ctrl_in = {i_RegDst, i_ALUSrc, i_Branch, i_MemRead, i_MemWrite,
                      i_RegWrite, i_MemtoReg, i_ALUOp};
    assign cnt_inc = (bubble_cnt_q == CNT_MAX) ? bubble_cnt_q : bubble_cnt_q + CNT_ONE;

    // Next-state selection: flush > stall > bubble > load (hold by default)
    always_comb begin
        ctrl_d       = ctrl_q;
        pc_next_d    = pc_next_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        valid_d      = valid_q;
        bubble_cnt_d = bubble_cnt_q;
        if (i_flush) begin
            ctrl_d       = '0;
            pc_next_d    = '0;
            rs_data_d    = '0;
            rt_data_d    = '0;
            imm_d        = '0;
            rs_d         = '0;
            rt_d         = '0;
            rd_d         = '0;
            valid_d      = 1'b0;
            bubble_cnt_d = cnt_inc;
        end else if (!i_stall) begin
            // Bubble and load both capture operands; only control/valid differ
            pc_next_d = i_pc_next;
            rs_data_d = i_rs_data;
            rt_data_d = i_rt_data;
            imm_d     = i_imm;
            rs_d      = i_rs;
            rt_d      = i_rt;
            rd_d      = i_rd;
            if (i_bubble) begin
                ctrl_d       = '0;
                valid_d      = 1'b0;
                bubble_cnt_d = cnt_inc;
            end else begin
                ctrl_d  = i_valid ? ctrl_in : '0;
                valid_d = i_valid;
            end
        end
    end

    // Pipeline register with synchronous active-low clear
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ctrl_q       <= '0;
            pc_next_q    <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            pc_next_q    <= pc_next_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            valid_q      <= valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign {o_RegDst, o_ALUSrc, o_Branch, o_MemRead, o_MemWrite,
            o_RegWrite, o_MemtoReg, o_ALUOp} = ctrl_q;
    assign o_pc_next    = pc_next_q;
    assign o_rs_data    = rs_data_q;
    assign o_rt_data    = rt_data_q;
    assign o_imm        = imm_q;
    assign o_rs         = rs_q;
    assign o_rt         = rt_q;
    assign o_rd         = rd_q;
    assign o_valid      = valid_q;
    assign o_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: directed scenarios plus randomized traffic,
// all checked against a slot-level reference model.
module tb_id_ex_reg;

    typedef struct packed {
        logic        regdst;
        logic        alusrc;
        logic        branch;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
        logic        memtoreg;
        logic [1:0]  aluop;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        valid;
    } slot_t;

    typedef struct packed {
        slot_t       f;
        logic [15:0] cnt;
    } ex_t;

    logic  clk = 1'b0;
    logic  rst_n, bub, stl, fls;
    slot_t din;
    ex_t   obs, exp_s;
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_RegDst(din.regdst), .i_ALUSrc(din.alusrc), .i_Branch(din.branch),
        .i_MemRead(din.memread), .i_MemWrite(din.memwrite),
        .i_RegWrite(din.regwrite), .i_MemtoReg(din.memtoreg), .i_ALUOp(din.aluop),
        .i_pc_next(din.pc), .i_rs_data(din.rs_data), .i_rt_data(din.rt_data),
        .i_imm(din.imm), .i_rs(din.rs), .i_rt(din.rt), .i_rd(din.rd),
        .i_valid(din.valid), .i_bubble(bub), .i_stall(stl), .i_flush(fls),
        .o_RegDst(obs.f.regdst), .o_ALUSrc(obs.f.alusrc), .o_Branch(obs.f.branch),
        .o_MemRead(obs.f.memread), .o_MemWrite(obs.f.memwrite),
        .o_RegWrite(obs.f.regwrite), .o_MemtoReg(obs.f.memtoreg), .o_ALUOp(obs.f.aluop),
        .o_pc_next(obs.f.pc), .o_rs_data(obs.f.rs_data), .o_rt_data(obs.f.rt_data),
        .o_imm(obs.f.imm), .o_rs(obs.f.rs), .o_rt(obs.f.rt), .o_rd(obs.f.rd),
        .o_valid(obs.f.valid), .o_bubble_cnt(obs.cnt)
    );

    function automatic logic [15:0] sat_inc(logic [15:0] c);
        int n = int'(c) + 1;
        if (n > 65535) n = 65535;
        return 16'(n);
    endfunction

    // Slot-level reference: what the EX slot holds after one edge
    function automatic ex_t model_next(ex_t cur, slot_t in, logic r, logic b, logic s, logic f);
        ex_t nxt;
        if (!r) return '0;
        if (f) begin
            nxt     = '0;
            nxt.cnt = sat_inc(cur.cnt);
            return nxt;
        end
        if (s) return cur;
        nxt.cnt = cur.cnt;
        nxt.f   = in;
        if (b || !in.valid) begin
            nxt.f.regdst = 0; nxt.f.alusrc = 0; nxt.f.branch = 0; nxt.f.memread = 0;
            nxt.f.memwrite = 0; nxt.f.regwrite = 0; nxt.f.memtoreg = 0; nxt.f.aluop = 0;
        end
        if (b) begin
            nxt.f.valid = 0;
            nxt.cnt     = sat_inc(cur.cnt);
        end
        return nxt;
    endfunction

    function automatic slot_t rand_slot();
        slot_t s;
        s.regdst = 1'($urandom); s.alusrc = 1'($urandom); s.branch = 1'($urandom);
        s.memread = 1'($urandom); s.memwrite = 1'($urandom); s.regwrite = 1'($urandom);
        s.memtoreg = 1'($urandom); s.aluop = 2'($urandom);
        s.pc = $urandom; s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
        s.rs = 5'($urandom); s.rt = 5'($urandom); s.rd = 5'($urandom);
        s.valid = 1'($urandom);
        return s;
    endfunction

    function automatic slot_t ops_only();
        slot_t s = rand_slot();
        s.regdst = 0; s.alusrc = 0; s.branch = 0; s.memread = 0; s.memwrite = 0;
        s.regwrite = 0; s.memtoreg = 0; s.aluop = 0; s.valid = 1;
        return s;
    endfunction

    task automatic tick();
        exp_s = model_next(exp_s, din, rst_n, bub, stl, fls);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; bub = 1; stl = 1; fls = 0; din = rand_slot(); din.valid = 1;
        exp_s = rand_slot();
        tick();
        tick();
        n_cmp++;
        if (obs !== ex_t'(0)) begin
            n_err++; $display("FAIL reset: got %h want 0", obs);
        end
    endtask

    task automatic test_load();
        rst_n = 1; bub = 0; stl = 0; fls = 0;
        din = ops_only(); din.regdst = 1; din.regwrite = 1; din.aluop = 2'b10;
        din.rs_data = 32'h5;
        tick();
        n_cmp++;
        if (obs.f !== din || obs.f.valid !== 1'b1 || obs.f.rs_data !== 32'h5) begin
            n_err++; $display("FAIL load_rformat: got %h want %h", obs.f, din);
        end
        n_cmp++;
        if (obs !== exp_s) begin
            n_err++; $display("FAIL load_model: got %h want %h", obs, exp_s);
        end
        din.valid = 0;
        tick();
        n_cmp++;
        if (obs !== exp_s || {obs.f.regdst, obs.f.regwrite, obs.f.aluop} !== 4'b0) begin
            n_err++; $display("FAIL load_invalid: got %h want %h", obs, exp_s);
        end
    endtask

    task automatic test_bubble();
        slot_t dep;
        din = ops_only(); din.alusrc = 1; din.memread = 1; din.memtoreg = 1; din.regwrite = 1;
        tick();
        dep = ops_only(); dep.regdst = 1; dep.regwrite = 1; dep.aluop = 2'b10;
        din = dep; bub = 1;
        tick();
        n_cmp++;
        if (obs.f.valid !== 1'b0 || obs.cnt !== 16'd1 || obs.f.rs_data !== dep.rs_data ||
            {obs.f.regdst, obs.f.alusrc, obs.f.branch, obs.f.memread, obs.f.memwrite,
             obs.f.regwrite, obs.f.memtoreg, obs.f.aluop} !== 9'b0) begin
            n_err++; $display("FAIL bubble: got %h want ctrl=0 valid=0 cnt=1", obs);
        end
        bub = 0;
        tick();
        n_cmp++;
        if (obs.f !== dep || obs.cnt !== 16'd1) begin
            n_err++; $display("FAIL bubble_reload: got %h want %h", obs, {dep, 16'd1});
        end
    endtask

    task automatic test_flush_stall();
        logic [15:0] c0 = exp_s.cnt;
        din = ops_only(); din.alusrc = 1; din.memwrite = 1;
        fls = 1; stl = 1;
        tick();
        n_cmp++;
        if (obs.f !== slot_t'(0) || obs.cnt !== c0 + 16'd1) begin
            n_err++; $display("FAIL flush_stall: got %h want slot=0 cnt=%h", obs, c0 + 16'd1);
        end
        fls = 0; stl = 0;
    endtask

    task automatic test_stall();
        ex_t held;
        din = ops_only(); din.branch = 1; din.aluop = 2'b01;
        tick();
        held = exp_s;
        stl = 1;
        for (int i = 0; i < 3; i++) begin
            din = rand_slot(); bub = 1'($urandom);
            tick();
            n_cmp++;
            if (obs !== held || obs.f.branch !== 1'b1) begin
                n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, held);
            end
        end
        stl = 0; bub = 0;
    endtask

    task automatic test_reset_mid();
        din = ops_only(); din.regwrite = 1;
        tick();
        stl = 1; rst_n = 0; bub = 1;
        tick();
        n_cmp++;
        if (obs !== ex_t'(0)) begin
            n_err++; $display("FAIL reset_mid_stall: got %h want 0", obs);
        end
        rst_n = 1; stl = 0; bub = 0;
        din = ops_only(); din.alusrc = 1; din.memread = 1; din.memtoreg = 1; din.regwrite = 1;
        tick();
        n_cmp++;
        if (obs !== exp_s || obs.f.memread !== 1'b1 || obs.f.memtoreg !== 1'b1) begin
            n_err++; $display("FAIL reset_release_lw: got %h want %h", obs, exp_s);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            din   = rand_slot();
            rst_n = ($urandom_range(0, 39) != 0);
            fls   = ($urandom_range(0, 7) == 0);
            stl   = ($urandom_range(0, 3) == 0);
            bub   = ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++;
            if (obs !== exp_s) begin
                n_err++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_s);
            end
        end
        rst_n = 1; fls = 0; stl = 0; bub = 0;
    endtask

    task automatic test_saturation();
        rst_n = 0; tick(); rst_n = 1;
        bub = 1;
        for (int i = 0; i < 65535; i++) begin
            din = ops_only();
            tick();
        end
        n_cmp++;
        if (obs.cnt !== 16'hFFFF || obs !== exp_s) begin
            n_err++; $display("FAIL sat_preload: got %h want ffff", obs.cnt);
        end
        tick();
        n_cmp++;
        if (obs.cnt !== 16'hFFFF) begin
            n_err++; $display("FAIL sat_bubble: got %h want ffff", obs.cnt);
        end
        bub = 0; fls = 1;
        tick();
        n_cmp++;
        if (obs.cnt !== 16'hFFFF || obs.f !== slot_t'(0)) begin
            n_err++; $display("FAIL sat_flush: got %h want ffff/slot 0", obs);
        end
        fls = 0;
    endtask

    initial begin
        rst_n = 0; bub = 0; stl = 0; fls = 0; din = '0; exp_s = '0;
        test_reset();
        test_load();
        test_bubble();
        test_flush_stall();
        test_stall();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
